// File: rtl/rand_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : rand_arbiter_if
//  Brief    : Request/grant bundle between rand_arbiter and its consumers.
//  Revision : 1.0 - initial release
// ============================================================================
interface rand_arbiter_if #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 4
);
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  gnt;
    logic [WIDTH-1:0] rand_word;
    logic             word_rdy;

    modport master (
        output req,
        input  gnt,
        input  rand_word,
        input  word_rdy
    );

    modport slave (
        input  req,
        output gnt,
        output rand_word,
        output word_rdy
    );
endinterface
`default_nettype wire

// File: rtl/rand_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rand_arbiter
//  Brief    : Packs the serial LFSR bit stream into WIDTH-bit words and hands
//             each word to exactly one requester (round-robin req/gnt).
//             Define RAND_ARB_FIXED_PRIO_EN for fixed priority (req0 highest).
//  Revision : 1.0 - initial release
// ============================================================================
module rand_arbiter #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        rand_bit,
    rand_arbiter_if.slave    bus
);
    localparam int c_IDX_W = $clog2(NREQ);
    localparam int c_CNT_W = $clog2(WIDTH + 1);

    localparam logic [0:0] c_ST_FILL  = 1'b0;
    localparam logic [0:0] c_ST_READY = 1'b1;

    localparam logic [NREQ-1:0]    c_GNT_ONE  = NREQ'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_sr;
    logic [WIDTH-1:0]   r_word;
    logic [c_CNT_W-1:0] r_cnt;
    logic [NREQ-1:0]    r_gnt;
    logic [c_IDX_W-1:0] w_win;
    logic               w_grant;
    logic               w_rdy;

`ifdef RAND_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest asserted index is the last to overwrite.
    always_comb begin
        w_win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[c_IDX_W'(i)]) begin
                w_win = c_IDX_W'(i);
            end
        end
    end
`else
    logic [c_IDX_W-1:0] r_last;
    logic               w_found;

    // Offset NREQ wraps back to r_last itself, giving it the lowest priority.
    always_comb begin
        w_win   = r_last;
        w_found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!w_found && bus.req[c_IDX_W'((int'(r_last) + i) % NREQ)]) begin
                w_win   = c_IDX_W'((int'(r_last) + i) % NREQ);
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= c_IDX_W'(NREQ - 1);
        end else if (w_grant) begin
            r_last <= w_win;
        end
    end
`endif

    assign w_grant = (r_state == c_ST_READY) && (|bus.req);

    // State register together with the datapath it sequences.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_FILL;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= '0;
            if (r_state == c_ST_FILL) begin
                r_sr  <= {r_sr[WIDTH-2:0], rand_bit};
                r_cnt <= r_cnt + c_CNT_W'(1);
            end else if (w_grant) begin
                r_gnt  <= c_GNT_ONE << w_win;
                r_word <= r_sr;
                r_cnt  <= '0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_FILL: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_ST_READY;
                end
            end
            c_ST_READY: begin
                if (|bus.req) begin
                    w_state_nxt = c_ST_FILL;
                end
            end
            default: w_state_nxt = c_ST_FILL;
        endcase
    end

    always_comb begin
        w_rdy = (r_state == c_ST_READY);
    end

    assign bus.gnt       = r_gnt;
    assign bus.rand_word = r_word;
    assign bus.word_rdy  = w_rdy;

endmodule
`default_nettype wire
